// File: rtl/seq_gen_burst_arbiter.sv
// seq_gen_burst_arbiter
//   Shares one external sequence_generator between two requesters. A granted
//   requester receives a burst of len consecutive generator words, captured
//   one per cycle and tagged with the owner's ID. Ties are broken round-robin.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   req        : per-requester request, held high until the matching ack bit
//   len_0/1    : burst length per requester, sampled only at grant
//   ack        : one-cycle grant pulse per requester
//   done       : one-cycle burst-complete pulse per requester
//   gen_enable : advance enable to the generator (high only in BURST)
//   gen_data   : current generator word
//   out_data   : captured word (holds its value while out_valid is low)
//   out_valid  : out_data carries a fresh word this cycle
//   out_id     : owner of out_data / current burst
//   busy       : block is not idle
module seq_gen_burst_arbiter #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  len_0,
  input  logic [LEN_W-1:0]  len_1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic              gen_enable,
  input  logic [DATA_W-1:0] gen_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_id,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [LEN_W-1:0]  cnt_q,        cnt_d;
  logic              rr_q,         rr_d;
  logic [1:0]        ack_q,        ack_d;
  logic [1:0]        done_q,       done_d;
  logic              gen_enable_q, gen_enable_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic              out_valid_q,  out_valid_d;
  logic              out_id_q,     out_id_d;
  logic              busy_q,       busy_d;

  logic              winner;
  logic [LEN_W-1:0]  win_len;

  // Arbitration: a lone requester wins outright; on a tie the requester that
  // did not win last time (rr_q holds the last winner) takes the grant.
  always_comb begin
    winner  = 1'b0;
    win_len = '0;
    if (req == 2'b11) begin
      winner = ~rr_q;
    end else begin
      winner = req[1];
    end
    win_len = winner ? len_1 : len_0;
  end

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    ack_d       = '0;
    done_d      = '0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          out_id_d      = winner;
          cnt_d         = win_len;
          ack_d[winner] = 1'b1;
          rr_d          = winner;
          // A zero-length burst skips BURST entirely and just signals done.
          state_d       = (win_len == '0) ? S_DONE : S_BURST;
        end
      end
      S_BURST: begin
        // The generator advances on this same edge, so the next capture is
        // the following sequence word.
        out_data_d  = gen_data;
        out_valid_d = 1'b1;
        cnt_d       = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d[out_id_q] = 1'b1;
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered decodes of the next state keep these outputs glitch-free.
    gen_enable_d = (state_d == S_BURST);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rr_q         <= 1'b1;
      ack_q        <= '0;
      done_q       <= '0;
      gen_enable_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      gen_enable_q <= gen_enable_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      busy_q       <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign gen_enable = gen_enable_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_id     = out_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_gen_burst_arbiter.sv
module tb_seq_gen_burst_arbiter;

  localparam int LEN_W  = 4;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        req = 2'b00;
  logic [LEN_W-1:0]  len_0 = '0;
  logic [LEN_W-1:0]  len_1 = '0;
  logic [1:0]        ack;
  logic [1:0]        done;
  logic              gen_enable;
  logic [DATA_W-1:0] gen_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_id;
  logic              busy;

  seq_gen_burst_arbiter #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req(req), .len_0(len_0), .len_1(len_1),
    .ack(ack), .done(done), .gen_enable(gen_enable), .gen_data(gen_data),
    .out_data(out_data), .out_valid(out_valid), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural sequence_generator: cyclic A,B,E,7,F,2,0,D, shares reset.
  logic [3:0] seq_tab [8] = '{4'hA, 4'hB, 4'hE, 4'h7, 4'hF, 4'h2, 4'h0, 4'hD};
  logic [2:0] gidx;
  always @(posedge clk or posedge reset) begin
    if (reset) gidx <= 3'd0;
    else if (gen_enable) gidx <= gidx + 3'd1;
  end
  assign gen_data = seq_tab[gidx];

  // Scoreboard
  typedef struct { logic id; logic [3:0] data; } word_t;
  typedef struct { logic id; logic had; } done_t;
  word_t exp_w[$];
  int    exp_ack[$];
  done_t exp_done[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: sequence position and last winner.
  int   m_pos = 0;
  logic m_rr  = 1'b1;

  int gen_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  word_t      mon_w;
  done_t      mon_d;
  int         mon_a;
  logic       prev_valid = 1'b0;
  logic [3:0] last_data  = 4'h0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      last_data  = 4'h0;
    end else begin
      if (out_valid) begin
        if (exp_w.size() == 0) check("spurious_word", 1, 0);
        else begin
          mon_w = exp_w.pop_front();
          check("word_data", 32'(out_data), 32'(mon_w.data));
          check("word_id", 32'(out_id), 32'(mon_w.id));
        end
        last_data = out_data;
      end else if (prev_valid) begin
        check("data_hold", 32'(out_data), 32'(last_data));
      end
      if (ack != 2'b00) begin
        if (exp_ack.size() == 0) check("spurious_ack", 32'(ack), 0);
        else begin
          mon_a = exp_ack.pop_front();
          check("ack", 32'(ack), 32'(2'b01 << mon_a));
        end
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) check("spurious_done", 32'(done), 0);
        else begin
          mon_d = exp_done.pop_front();
          check("done", 32'(done), 32'(2'b01 << mon_d.id));
          check("done_after_last_word", 32'(prev_valid), 32'(mon_d.had));
        end
      end
      if (gen_enable) gen_cnt++;
      prev_valid = out_valid;
    end
  end

  task automatic model_burst(input logic id, input int len);
    word_t w;
    done_t d;
    exp_ack.push_back(int'(id));
    for (int k = 0; k < len; k++) begin
      w.id   = id;
      w.data = seq_tab[m_pos % 8];
      exp_w.push_back(w);
      m_pos++;
    end
    d.id  = id;
    d.had = (len > 0);
    exp_done.push_back(d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_gen_enable", 32'(gen_enable), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_busy", 32'(busy), 0);
    exp_w.delete();
    exp_ack.delete();
    exp_done.delete();
    m_pos = 0;
    m_rr  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One arbitration round: raise the chosen requests together and let each
  // requester drop its request when acknowledged.
  task automatic round(input logic r0, input logic r1, input int l0, input int l1);
    int   n_done;
    int   want;
    int   g0;
    logic first;
    bit   ok;
    if (r0 && r1) begin
      first = ~m_rr;
      model_burst(first, first ? l1 : l0);
      model_burst(~first, first ? l0 : l1);
      m_rr = ~first;
    end else begin
      first = r1;
      model_burst(first, first ? l1 : l0);
      m_rr = first;
    end
    want   = int'(r0) + int'(r1);
    n_done = 0;
    ok     = 1'b0;
    g0     = gen_cnt;
    len_0  = LEN_W'(l0);
    len_1  = LEN_W'(l1);
    req    = {r1, r0};
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ack[0]) req[0] = 1'b0;
      if (ack[1]) req[1] = 1'b0;
      n_done += int'(done[0]) + int'(done[1]);
      if (n_done >= want) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("round_timeout", 1, 0);
      req = 2'b00;
    end
    @(negedge clk);
    check("gen_enable_cycles", 32'(gen_cnt - g0), 32'((r0 ? l0 : 0) + (r1 ? l1 : 0)));
    check("idle_after_round", 32'({busy, out_valid}), 0);
    check("words_drained", 32'(exp_w.size()), 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single bursts back to back; the sequence continues across bursts.
    round(1'b1, 1'b0, 3, 0);
    round(1'b0, 1'b1, 0, 2);

    // Tie: requester 0 wins first, then alternation.
    do_reset();
    round(1'b1, 1'b1, 1, 1);
    round(1'b1, 1'b1, 1, 1);

    // Long burst with wrap D->A.
    do_reset();
    round(1'b1, 1'b0, 10, 0);

    // Zero-length burst, then the next burst still starts at A.
    do_reset();
    round(1'b1, 1'b0, 0, 0);
    round(1'b1, 1'b0, 2, 0);

    // Reset during the third word of a five-word burst.
    do_reset();
    model_burst(1'b0, 5);
    len_0 = LEN_W'(5);
    req   = 2'b01;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (ack[0]) req[0] = 1'b0;
      if (exp_w.size() <= 2) break;
    end
    check("abort_reached_third_word", 32'(exp_w.size()), 2);
    do_reset();
    round(1'b1, 1'b0, 2, 0);

    // Randomised rounds against the model.
    for (int i = 0; i < 40; i++) begin
      int rs;
      rs = int'($urandom_range(3, 1));
      round(rs[0], rs[1], int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    end

    check("ack_drained", 32'(exp_ack.size()), 0);
    check("done_drained", 32'(exp_done.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
